// File: rtl/cim_pkg.sv
// Shared types and width helpers for the CIM crossbar model.
// Used by cim_xbar_model and cim_xbar_dot.
package cim_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Result width: one DATA_SIZE x DATA_SIZE product grown by the row count.
  function automatic int obuf_data_size(input int data_size, input int xbar_size);
    return 2 * data_size + $clog2(xbar_size);
  endfunction

endpackage

// File: rtl/cim_xbar_dot.sv
// Combinational dot product of a binary input vector against one weight column.
// CIM_XBAR_SIGNED_EN selects two's-complement weights.
module cim_xbar_dot #(
  parameter int DATA_SIZE = 8,
  parameter int XBAR_SIZE = 128,
  parameter int DOT_W     = DATA_SIZE + $clog2(XBAR_SIZE)
) (
  input  logic [XBAR_SIZE-1:0]                in_vec,
  input  logic [XBAR_SIZE-1:0][DATA_SIZE-1:0] col,
  output logic [DOT_W-1:0]                    dot
);

  logic [DOT_W-1:0] sum;
  logic [DOT_W-1:0] wgt_ext;

  always_comb begin
    // NOTE: blocking assignments here build a combinational adder chain;
    // every variable gets a value before the loop so no latch is inferred.
    sum     = '0;
    wgt_ext = '0;
    for (int r = 0; r < XBAR_SIZE; r++) begin
`ifdef CIM_XBAR_SIGNED_EN
      wgt_ext = {{(DOT_W-DATA_SIZE){col[r][DATA_SIZE-1]}}, col[r]};
`else
      wgt_ext = DOT_W'(col[r]);
`endif
      if (in_vec[r]) sum = sum + wgt_ext;
    end
    dot = sum;
  end

endmodule

// File: rtl/cim_xbar_model.sv
// Single-tile bit-serial crossbar MVM model with addressed result readout.
// Optional CIM_XBAR_SIGNED_EN: signed weights, last plane is the input sign plane.
module cim_xbar_model
  import cim_pkg::*;
#(
  parameter int DATA_SIZE           = 8,
  parameter int XBAR_SIZE           = 128,
  parameter int BUS_WIDTH           = 16,
  parameter int OBUF_BUS_WIDTH      = 48,
  localparam int OBUF_DATA_SIZE     = obuf_data_size(DATA_SIZE, XBAR_SIZE),
  localparam int NUM_CHANNELS       = OBUF_BUS_WIDTH / OBUF_DATA_SIZE,
  localparam int ELEMENTS_PER_TILE  = XBAR_SIZE / DATA_SIZE,
  localparam int NUM_ADDR           = (XBAR_SIZE + BUS_WIDTH - 1) / BUS_WIDTH,
  localparam int NUM_ADDR_OBUF      = (ELEMENTS_PER_TILE + NUM_CHANNELS - 1) / NUM_CHANNELS,
  localparam int ADDR_W             = clog2_min1(NUM_ADDR),
  localparam int OBUF_ADDR_W        = clog2_min1(NUM_ADDR_OBUF),
  localparam int ROW_W              = clog2_min1(XBAR_SIZE)
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_we,
  input  logic [ADDR_W-1:0]                             i_addr,
  input  logic [BUS_WIDTH-1:0]                          i_data,
  input  logic                                          i_start,
  output logic                                          o_ready,
  output logic                                          o_valid,
  input  logic                                          i_wgt_we,
  input  logic [ROW_W-1:0]                              i_wgt_row,
  input  logic [ELEMENTS_PER_TILE*DATA_SIZE-1:0]        i_wgt_data,
  input  logic [OBUF_ADDR_W-1:0]                        i_obuf_addr,
  output logic [NUM_CHANNELS-1:0][OBUF_DATA_SIZE-1:0]   o_data
);

  localparam int E_W   = clog2_min1(ELEMENTS_PER_TILE);
  localparam int P_W   = clog2_min1(DATA_SIZE);
  localparam int DOT_W = DATA_SIZE + $clog2(XBAR_SIZE);
  localparam logic [E_W-1:0] E_LAST = E_W'(ELEMENTS_PER_TILE - 1);
  localparam logic [P_W-1:0] P_LAST = P_W'(DATA_SIZE - 1);

  state_t                         state_q, state_d;
  logic [E_W-1:0]                 e_cnt;
  logic [P_W-1:0]                 plane;
  logic                           valid_q;
  logic [XBAR_SIZE-1:0]           in_reg;
  logic [XBAR_SIZE-1:0]           cmp_vec;
  logic [OBUF_DATA_SIZE-1:0]      acc [ELEMENTS_PER_TILE];
  logic [ELEMENTS_PER_TILE*DATA_SIZE-1:0] wgt_mem [XBAR_SIZE];
  logic [XBAR_SIZE-1:0][DATA_SIZE-1:0]    col;
  logic [DOT_W-1:0]               dot;
  logic [OBUF_DATA_SIZE-1:0]      dot_ext, term, acc_base, acc_nxt;
  logic                           start_ok, last_elem;

  always_comb begin
    state_d   = state_q;
    start_ok  = 1'b0;
    last_elem = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = COMPUTE;
          start_ok = 1'b1;
        end
      end
      COMPUTE: begin
        if (e_cnt == E_LAST) begin
          state_d   = IDLE;
          last_elem = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_ready = (state_q == IDLE);
  assign o_valid = valid_q;

  always_comb begin
    for (int r = 0; r < XBAR_SIZE; r++)
      col[r] = wgt_mem[r][int'(e_cnt)*DATA_SIZE +: DATA_SIZE];
  end

  cim_xbar_dot #(
    .DATA_SIZE (DATA_SIZE),
    .XBAR_SIZE (XBAR_SIZE),
    .DOT_W     (DOT_W)
  ) u_dot (
    .in_vec (cmp_vec),
    .col    (col),
    .dot    (dot)
  );

  always_comb begin
`ifdef CIM_XBAR_SIGNED_EN
    dot_ext = {{(OBUF_DATA_SIZE-DOT_W){dot[DOT_W-1]}}, dot};
`else
    dot_ext = OBUF_DATA_SIZE'(dot);
`endif
    term     = dot_ext << plane;
    acc_base = (plane == '0) ? '0 : acc[e_cnt];
`ifdef CIM_XBAR_SIGNED_EN
    // The top plane carries the input sign bit, so its weight is negative.
    acc_nxt  = (plane == P_LAST) ? (acc_base - term) : (acc_base + term);
`else
    acc_nxt  = acc_base + term;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others (this is what makes
  // a same-cycle write and start snapshot the old input register).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      e_cnt   <= '0;
      plane   <= '0;
      valid_q <= 1'b0;
      in_reg  <= '0;
      cmp_vec <= '0;
      for (int e = 0; e < ELEMENTS_PER_TILE; e++) acc[e] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && i_we && int'(i_addr) < NUM_ADDR) begin
        for (int b = 0; b < BUS_WIDTH; b++) begin
          if (int'(i_addr)*BUS_WIDTH + b < XBAR_SIZE)
            in_reg[int'(i_addr)*BUS_WIDTH + b] <= i_data[b];
        end
      end
      if (start_ok) begin
        cmp_vec <= in_reg;
        if (plane == '0) valid_q <= 1'b0;
      end
      if (state_q == COMPUTE) begin
        acc[e_cnt] <= acc_nxt;
        e_cnt      <= last_elem ? '0 : e_cnt + E_W'(1);
        if (last_elem) begin
          plane <= (plane == P_LAST) ? '0 : plane + P_W'(1);
          if (plane == P_LAST) valid_q <= 1'b1;
        end
      end
    end
  end

  // NOTE: the weight array has no reset; it is storage loaded by software,
  // and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && i_wgt_we) wgt_mem[i_wgt_row] <= i_wgt_data;
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      o_data[c] = '0;
      if (int'(i_obuf_addr) < NUM_ADDR_OBUF &&
          int'(i_obuf_addr)*NUM_CHANNELS + c < ELEMENTS_PER_TILE)
        o_data[c] = acc[int'(i_obuf_addr)*NUM_CHANNELS + c];
    end
  end

endmodule

// File: tb/tb_cim_xbar_model.sv
// Directed self-checking bench for cim_xbar_model in a 2-bit, 8-row configuration.
// Define CIM_XBAR_SIGNED_EN to run the signed-plane vector instead of the unsigned ones.
module tb_cim_xbar_model;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_we = 1'b0;
  logic [0:0]      i_addr = '0;
  logic [3:0]      i_data = '0;
  logic            i_start = 1'b0;
  logic            o_ready;
  logic            o_valid;
  logic            i_wgt_we = 1'b0;
  logic [2:0]      i_wgt_row = '0;
  logic [7:0]      i_wgt_data = '0;
  logic [0:0]      i_obuf_addr = '0;
  logic [1:0][6:0] o_data;

  int n_checks = 0;
  int n_errors = 0;

  cim_xbar_model #(
    .DATA_SIZE      (2),
    .XBAR_SIZE      (8),
    .BUS_WIDTH      (4),
    .OBUF_BUS_WIDTH (14)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_start     (i_start),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_wgt_we    (i_wgt_we),
    .i_wgt_row   (i_wgt_row),
    .i_wgt_data  (i_wgt_data),
    .i_obuf_addr (i_obuf_addr),
    .o_data      (o_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic write_in(input logic a, input logic [3:0] d);
    i_we = 1'b1; i_addr = a; i_data = d;
    @(negedge clk);
    i_we = 1'b0;
  endtask

  task automatic write_wgt(input logic [2:0] row, input logic [7:0] d);
    i_wgt_we = 1'b1; i_wgt_row = row; i_wgt_data = d;
    @(negedge clk);
    i_wgt_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(o_ready), 32'd1);
  endtask

  task automatic run_plane(input string tag);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_idle(tag);
  endtask

  task automatic read_obuf(input string tag, input logic a, input logic [6:0] e0, input logic [6:0] e1);
    i_obuf_addr = a;
    #1;
    check({tag, "_c0"}, 32'(o_data[0]), 32'(e0));
    check({tag, "_c1"}, 32'(o_data[1]), 32'(e1));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    read_obuf("rst_a0", 1'b0, 7'd0, 7'd0);
    read_obuf("rst_a1", 1'b1, 7'd0, 7'd0);
    rst = 1'b1;
    @(negedge clk);

`ifdef CIM_XBAR_SIGNED_EN
    // Weights +1, plane 0 all zeros, sign plane all ones: acc = -(8 << 1) = -16.
    for (int r = 0; r < 8; r++) write_wgt(3'(r), 8'h55);
    write_in(1'b0, 4'h0); write_in(1'b1, 4'h0);
    run_plane("s_p0_done");
    write_in(1'b0, 4'hF); write_in(1'b1, 4'hF);
    run_plane("s_p1_done");
    check("s_valid", 32'(o_valid), 32'd1);
    read_obuf("s_a0", 1'b0, 7'h70, 7'h70);
    read_obuf("s_a1", 1'b1, 7'h70, 7'h70);
`else
    // All weights 3, all inputs 1: 24 per plane, 24 + 48 after both planes.
    for (int r = 0; r < 8; r++) write_wgt(3'(r), 8'hFF);
    write_in(1'b0, 4'hF); write_in(1'b1, 4'hF);
    run_plane("a_p0_done");
    check("a_p0_valid", 32'(o_valid), 32'd0);
    read_obuf("a_p0_a0", 1'b0, 7'd24, 7'd24);
    run_plane("a_p1_done");
    check("a_p1_valid", 32'(o_valid), 32'd1);
    read_obuf("a_p1_a0", 1'b0, 7'd72, 7'd72);
    read_obuf("a_p1_a1", 1'b1, 7'd72, 7'd72);

    // Element 0 weight = row index (2 bits), input 0x0F: acc[0] = 0+1+2+3.
    for (int r = 0; r < 8; r++) write_wgt(3'(r), {6'd0, 2'(r)});
    write_in(1'b0, 4'hF); write_in(1'b1, 4'h0);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("t_busy1", 32'(o_ready), 32'd0);
    i_we = 1'b1; i_addr = 1'b1; i_data = 4'hF;
    i_wgt_we = 1'b1; i_wgt_row = 3'd0; i_wgt_data = 8'hFF;
    i_start = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("t_busy%0d", k), 32'(o_ready), 32'd0);
    end
    i_we = 1'b0; i_wgt_we = 1'b0; i_start = 1'b0;
    @(negedge clk);
    check("t_ready_back", 32'(o_ready), 32'd1);
    check("b_p0_valid", 32'(o_valid), 32'd0);
    read_obuf("b_p0_a0", 1'b0, 7'd6, 7'd0);
    read_obuf("b_p0_a1", 1'b1, 7'd0, 7'd0);
    write_in(1'b0, 4'h0);
    run_plane("b_p1_done");
    check("b_p1_valid", 32'(o_valid), 32'd1);
    read_obuf("b_p1_a0", 1'b0, 7'd6, 7'd0);
    read_obuf("b_p1_a1", 1'b1, 7'd0, 7'd0);

    // Write and start in the same cycle: plane 0 sees the old all-zero register.
    i_we = 1'b1; i_addr = 1'b0; i_data = 4'hF; i_start = 1'b1;
    @(negedge clk);
    i_we = 1'b0; i_start = 1'b0;
    wait_idle("c_p0_done");
    check("c_p0_valid", 32'(o_valid), 32'd0);
    read_obuf("c_p0_a0", 1'b0, 7'd0, 7'd0);
    run_plane("c_p1_done");
    check("c_p1_valid", 32'(o_valid), 32'd1);
    read_obuf("c_p1_a0", 1'b0, 7'd12, 7'd0);

    // Reset in the middle of the second plane, then plane sequence restarts at 0.
    run_plane("d_p0_done");
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("d_rst_ready", 32'(o_ready), 32'd1);
    check("d_rst_valid", 32'(o_valid), 32'd0);
    read_obuf("d_rst_a0", 1'b0, 7'd0, 7'd0);
    @(negedge clk);
    check("d_rst_ready_next", 32'(o_ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    write_in(1'b0, 4'hF);
    run_plane("d_after_done");
    check("d_after_valid", 32'(o_valid), 32'd0);
    read_obuf("d_after_a0", 1'b0, 7'd6, 7'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
